// File: rtl/cmd_cfg_mc.sv
// cmd_cfg_mc: host command decoder and trigger/capture config register file with self-addressed channel RAM dump.
// Optional build macro DUMP_CKSUM_EN appends a mod-256 sum byte after the dumped samples.
module cmd_cfg_mc #(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           cmd,
  input  logic                  cmd_rdy,
  input  logic                  resp_sent,
  input  logic                  set_capture_done,
  input  logic [LOG2-1:0]       ram_addr,
  input  logic [NUM_CH*8-1:0]   rdata,
  output logic [5:0]            TrigCfg,
  output logic [NUM_CH*5-1:0]   ChTrigCfg,
  output logic [3:0]            decimator,
  output logic [7:0]            VIH,
  output logic [7:0]            VIL,
  output logic [7:0]            matchH,
  output logic [7:0]            matchL,
  output logic [7:0]            maskH,
  output logic [7:0]            maskL,
  output logic [7:0]            baud_cntH,
  output logic [7:0]            baud_cntL,
  output logic [LOG2-1:0]       trig_pos,
  output logic [7:0]            resp,
  output logic                  send_resp,
  output logic                  clr_cmd_rdy,
  output logic                  rd_en,
  output logic [LOG2-1:0]       rd_addr,
  output logic                  dump_busy
);
  typedef enum logic [2:0] {IDLE, RESPOND, D_RD, D_LAT, D_SEND, D_WAIT, D_CKW} state_t;
  state_t state, state_n;

  logic [1:0]      op;
  logic [5:0]      addr;
  logic [7:0]      data;
  logic [4:0]      ch_cfg [NUM_CH];
  logic [LOG2-1:0] ptr, cnt;
  logic [4:0]      ch_sel;
  logic [15:0]     tp16;
  logic [7:0]      rd_val, byte_sel, resp_n;
  logic            reg_ok, dmp_ok, clr_n, load_resp, wr_en, start_dump, advance;
`ifdef DUMP_CKSUM_EN
  logic [7:0]      sum;
`endif

  assign op        = cmd[15:14];
  assign addr      = cmd[13:8];
  assign data      = cmd[7:0];
  // trig_pos seen as a 16-bit value; upper byte reads 0 and writes vanish when LOG2 <= 8
  assign tp16      = 16'(trig_pos);
  assign rd_addr   = ptr;
  assign dump_busy = (state != IDLE) && (state != RESPOND);
  assign dmp_ok    = (cmd[12:8] != 5'd0) && (int'(cmd[12:8]) <= NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ChTrigCfg[g*5 +: 5] = ch_cfg[g];
  end

  always_comb begin
    reg_ok = 1'b1;
    rd_val = '0;
    case (addr)
      6'h00: rd_val = {2'b0, TrigCfg};
      6'h06: rd_val = {4'b0, decimator};
      6'h07: rd_val = VIH;
      6'h08: rd_val = VIL;
      6'h09: rd_val = matchH;
      6'h0A: rd_val = matchL;
      6'h0B: rd_val = maskH;
      6'h0C: rd_val = maskL;
      6'h0D: rd_val = baud_cntH;
      6'h0E: rd_val = baud_cntL;
      6'h0F: rd_val = tp16[15:8];
      6'h10: rd_val = tp16[7:0];
      default: begin
        reg_ok = addr[5] && (int'(addr[4:0]) < NUM_CH);
        for (int i = 0; i < NUM_CH; i++)
          if (addr[4:0] == 5'(i)) rd_val = {3'b0, ch_cfg[i]};
      end
    endcase
  end

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel == 5'(i)) byte_sel = rdata[i*8 +: 8];
  end

  always_comb begin
    state_n    = state;
    clr_n      = 1'b0;
    rd_en      = 1'b0;
    load_resp  = 1'b0;
    resp_n     = 8'hEE;
    wr_en      = 1'b0;
    start_dump = 1'b0;
    advance    = 1'b0;
    case (state)
      // clr_cmd_rdy high means the host has not yet dropped the finished command
      IDLE: if (cmd_rdy && !clr_cmd_rdy) begin
        load_resp = 1'b1;
        state_n   = RESPOND;
        case (op)
          2'b00: if (reg_ok) resp_n = rd_val;
          2'b01: if (reg_ok) begin resp_n = 8'hA5; wr_en = 1'b1; end
          2'b10: if (dmp_ok) begin load_resp = 1'b0; start_dump = 1'b1; state_n = D_RD; end
          default: ;
        endcase
      end
      RESPOND: if (resp_sent) begin clr_n = 1'b1; state_n = IDLE; end
      D_RD:    begin rd_en = 1'b1; state_n = D_LAT; end
      D_LAT:   begin load_resp = 1'b1; resp_n = byte_sel; state_n = D_SEND; end
      D_SEND:  state_n = D_WAIT;
      D_WAIT: if (resp_sent) begin
        if (cnt == LOG2'(ENTRIES-1)) begin
`ifdef DUMP_CKSUM_EN
          load_resp = 1'b1;
          resp_n    = sum;
          state_n   = D_CKW;
`else
          clr_n   = 1'b1;
          state_n = IDLE;
`endif
        end else begin
          advance = 1'b1;
          state_n = D_RD;
        end
      end
      D_CKW:   if (resp_sent) begin clr_n = 1'b1; state_n = IDLE; end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TrigCfg     <= 6'h03;
      for (int i = 0; i < NUM_CH; i++) ch_cfg[i] <= 5'h01;
      decimator   <= '0;
      VIH         <= 8'hAA;
      VIL         <= 8'h55;
      matchH      <= '0;
      matchL      <= '0;
      maskH       <= '0;
      maskL       <= '0;
      baud_cntH   <= 8'h06;
      baud_cntL   <= 8'hC8;
      trig_pos    <= LOG2'(1);
      resp        <= '0;
      send_resp   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
      ch_sel      <= '0;
    end else begin
      send_resp   <= load_resp;
      clr_cmd_rdy <= clr_n;
      if (load_resp) resp <= resp_n;
      if (start_dump) begin
        ptr    <= (ram_addr == LOG2'(ENTRIES-1)) ? '0 : ram_addr + 1'b1;
        cnt    <= '0;
        ch_sel <= cmd[12:8] - 5'd1;
      end
      if (advance) begin
        ptr <= (ptr == LOG2'(ENTRIES-1)) ? '0 : ptr + 1'b1;
        cnt <= cnt + 1'b1;
      end
      if (wr_en) begin
        case (addr)
          6'h00: TrigCfg   <= data[5:0];
          6'h06: decimator <= data[3:0];
          6'h07: VIH       <= data;
          6'h08: VIL       <= data;
          6'h09: matchH    <= data;
          6'h0A: matchL    <= data;
          6'h0B: maskH     <= data;
          6'h0C: maskL     <= data;
          6'h0D: baud_cntH <= data;
          6'h0E: baud_cntL <= data;
          6'h0F: trig_pos  <= LOG2'({data, tp16[7:0]});
          6'h10: trig_pos  <= LOG2'({tp16[15:8], data});
          default:
            for (int i = 0; i < NUM_CH; i++)
              if (addr[4:0] == 5'(i)) ch_cfg[i] <= data[4:0];
        endcase
      end
      // capture-done wins bit5 over a same-cycle host write
      if (set_capture_done) TrigCfg[5] <= 1'b1;
    end
  end

`ifdef DUMP_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             sum <= '0;
    else if (start_dump)    sum <= '0;
    else if (state == D_LAT) sum <= sum + byte_sel;
  end
`endif
endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Randomized self-checking bench for cmd_cfg_mc against a register-map/dump reference model.
`timescale 1ns/1ps
module tb_cmd_cfg_mc;
  localparam int NUM_CH  = 5;
  localparam int ENTRIES = 8;
  localparam int LOG2    = 3;
  localparam int CFGW    = 6 + NUM_CH*5 + 4 + 64 + LOG2;
`ifdef DUMP_CKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic                clk, rst_n, cmd_rdy, resp_sent, set_capture_done;
  logic [15:0]         cmd;
  logic [LOG2-1:0]     ram_addr, trig_pos, rd_addr;
  logic [NUM_CH*8-1:0] rdata;
  logic [5:0]          TrigCfg;
  logic [NUM_CH*5-1:0] ChTrigCfg;
  logic [3:0]          decimator;
  logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL, resp;
  logic                send_resp, clr_cmd_rdy, rd_en, dump_busy;

  cmd_cfg_mc #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
    .set_capture_done(set_capture_done), .ram_addr(ram_addr), .rdata(rdata),
    .TrigCfg(TrigCfg), .ChTrigCfg(ChTrigCfg), .decimator(decimator), .VIH(VIH), .VIL(VIL),
    .matchH(matchH), .matchL(matchL), .maskH(maskH), .maskL(maskL),
    .baud_cntH(baud_cntH), .baud_cntL(baud_cntL), .trig_pos(trig_pos), .resp(resp),
    .send_resp(send_resp), .clr_cmd_rdy(clr_cmd_rdy), .rd_en(rd_en), .rd_addr(rd_addr),
    .dump_busy(dump_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH*8-1:0] mem [ENTRIES];
  always @(posedge clk) if (rd_en) rdata <= mem[rd_addr];

  logic [LOG2-1:0] rd_log [$];
  always @(negedge clk) if (rd_en) rd_log.push_back(rd_addr);

  int vectors, miscompares;
  int model [64];
  bit mvalid [64];
  int tp;
  logic [7:0] got [$];
  bit clr_seen, busy_seen;
  logic [CFGW-1:0] act_cfg;
  assign act_cfg = {TrigCfg, ChTrigCfg, decimator, VIH, VIL, matchH, matchL,
                    maskH, maskL, baud_cntH, baud_cntL, trig_pos};

  function automatic void init_model();
    for (int a = 0; a < 64; a++) begin
      model[a]  = 0;
      mvalid[a] = (a == 0) || (a >= 6 && a <= 16) || (a >= 32 && a < 32 + NUM_CH);
      if (a >= 32 && a < 32 + NUM_CH) model[a] = 1;
    end
    model[0] = 3; model[7] = 'hAA; model[8] = 'h55; model[13] = 'h06; model[14] = 'hC8;
    tp = 1;
  endfunction

  function automatic int exp_read(input int a);
    if (!mvalid[a]) return 'hEE;
    if (a == 15) return tp >> 8;
    if (a == 16) return tp & 255;
    return model[a];
  endfunction

  function automatic bit model_write(input int a, input int d);
    if (!mvalid[a]) return 1'b0;
    case (a)
      0:  model[0] = d & 'h3F;
      6:  model[6] = d & 'h0F;
      15: tp = ((d << 8) | (tp & 255)) % (1 << LOG2);
      16: tp = ((tp & ~255) | d) % (1 << LOG2);
      default: model[a] = (a >= 32) ? (d & 'h1F) : d;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [CFGW-1:0] exp_cfg();
    logic [NUM_CH*5-1:0] ch;
    for (int i = 0; i < NUM_CH; i++) ch[i*5 +: 5] = 5'(model[32+i]);
    return {6'(model[0]), ch, 4'(model[6]), 8'(model[7]), 8'(model[8]), 8'(model[9]),
            8'(model[10]), 8'(model[11]), 8'(model[12]), 8'(model[13]), 8'(model[14]), LOG2'(tp)};
  endfunction

  function automatic void fill_mem();
    for (int i = 0; i < ENTRIES; i++)
      for (int c = 0; c < NUM_CH; c++) mem[i][c*8 +: 8] = 8'($urandom);
  endfunction

  // Host side: present a command, return each byte after a random UART delay, drop cmd_rdy on clr.
  task automatic run_cmd(input logic [15:0] c, input bit cd_pulse, input bit jitter_ram);
    int gap = 0;
    got.delete(); rd_log.delete(); clr_seen = 0; busy_seen = 0;
    @(negedge clk);
    cmd = c; cmd_rdy = 1'b1; set_capture_done = cd_pulse;
    for (int cyc = 0; cyc < 1000 && !clr_seen; cyc++) begin
      @(negedge clk);
      set_capture_done = 1'b0; resp_sent = 1'b0;
      if (jitter_ram) ram_addr = LOG2'($urandom_range(0, ENTRIES-1));
      if (dump_busy) busy_seen = 1;
      if (clr_cmd_rdy) begin clr_seen = 1; cmd_rdy = 1'b0; end
      else if (send_resp) begin got.push_back(resp); gap = $urandom_range(1, 3); end
      else if (gap > 0) begin gap--; if (gap == 0) resp_sent = 1'b1; end
    end
    if (!clr_seen) begin
      cmd_rdy = 1'b0; vectors++; miscompares++;
      $display("FAIL cmd_timeout cmd=%h: clr_cmd_rdy never seen", c);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (act_cfg !== exp_cfg()) begin
      miscompares++; $display("FAIL reset_cfg got %h exp %h", act_cfg, exp_cfg());
    end
    vectors++;
    if ({resp, send_resp, clr_cmd_rdy, rd_en, rd_addr, dump_busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_out got resp=%h send=%b clr=%b rd_en=%b rd_addr=%h busy=%b exp all 0",
               resp, send_resp, clr_cmd_rdy, rd_en, rd_addr, dump_busy);
    end
  endtask

  task automatic test_read_map();
    logic [7:0] spec_exp [3] = '{8'h06, 8'hC8, 8'h01};
    int spec_addr [3] = '{13, 14, 16};
    for (int k = 0; k < 3; k++) begin
      run_cmd({2'b00, 6'(spec_addr[k]), 8'h00}, 0, 0);
      vectors++;
      if (got.size() != 1 || got[0] !== spec_exp[k] || !clr_seen) begin
        miscompares++;
        $display("FAIL rd_reset_%0h got n=%0d b=%h clr=%0d exp %h", spec_addr[k], got.size(),
                 got.size() ? got[0] : 8'hxx, clr_seen, spec_exp[k]);
      end
    end
    for (int a = 0; a < 64; a++) begin
      run_cmd({2'b00, 6'(a), 8'($urandom)}, 0, 0);
      vectors++;
      if (got.size() != 1 || got[0] !== 8'(exp_read(a)) || resp !== 8'(exp_read(a))) begin
        miscompares++;
        $display("FAIL rd_map_%0h got n=%0d resp=%h exp %h", a, got.size(), resp, exp_read(a));
      end
    end
  endtask

  task automatic test_write();
    int a, d;
    bit ok;
    int plan_a [3] = '{'h22, 'h25, 'h0F};
    int plan_d [3] = '{'h1F, 'h3C, 'hFF};
    for (int k = 0; k < 33; k++) begin
      if (k < 3) begin a = plan_a[k]; d = plan_d[k]; end
      else begin
        if ($urandom_range(0, 1)) do a = $urandom_range(0, 63); while (!mvalid[a]);
        else a = $urandom_range(0, 63);
        d = $urandom_range(0, 255);
      end
      ok = model_write(a, d);
      run_cmd({2'b01, 6'(a), 8'(d)}, 0, 0);
      vectors++;
      if (got.size() != 1 || got[0] !== (ok ? 8'hA5 : 8'hEE)) begin
        miscompares++;
        $display("FAIL wr_resp_%0h got n=%0d resp=%h exp %h", a, got.size(), resp, ok ? 8'hA5 : 8'hEE);
      end
      vectors++;
      if (act_cfg !== exp_cfg()) begin
        miscompares++; $display("FAIL wr_cfg_%0h got %h exp %h", a, act_cfg, exp_cfg());
      end
      run_cmd({2'b00, 6'(a), 8'h00}, 0, 0);
      vectors++;
      if (got.size() != 1 || got[0] !== 8'(exp_read(a))) begin
        miscompares++; $display("FAIL wr_readback_%0h got resp=%h exp %h", a, resp, exp_read(a));
      end
    end
  endtask

  task automatic test_capture_done();
    int   seq_d  [3] = '{1, 1, 0};
    bit   seq_cd [3] = '{1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      void'(model_write(0, seq_d[k]));
      if (seq_cd[k]) model[0] = model[0] | 'h20;
      run_cmd({2'b01, 6'h00, 8'(seq_d[k])}, seq_cd[k], 0);
      vectors++;
      if (TrigCfg !== 6'(model[0])) begin
        miscompares++; $display("FAIL capdone_wr%0d got %h exp %h", k, TrigCfg, 6'(model[0]));
      end
    end
    @(negedge clk); set_capture_done = 1'b1;
    @(negedge clk); set_capture_done = 1'b0;
    model[0] = model[0] | 'h20;
    run_cmd({2'b00, 6'h00, 8'h00}, 0, 0);
    vectors++;
    if (got.size() != 1 || got[0] !== 8'(model[0]) || TrigCfg !== 6'(model[0])) begin
      miscompares++; $display("FAIL capdone_idle got TrigCfg=%h resp=%h exp %h", TrigCfg, resp, model[0]);
    end
  endtask

  task automatic test_dump(input int ra, input int ch);
    logic [7:0] eb;
    int sum = 0;
    fill_mem();
    ram_addr = LOG2'(ra);
    run_cmd({2'b10, 1'b0, 5'(ch), 8'h00}, 0, 1);
    vectors++;
    if (got.size() != ENTRIES + EXTRA || rd_log.size() != ENTRIES || !busy_seen || dump_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_shape ra=%0d ch=%0d got bytes=%0d reads=%0d busy_seen=%0d busy=%b exp %0d/%0d/1/0",
               ra, ch, got.size(), rd_log.size(), busy_seen, dump_busy, ENTRIES + EXTRA, ENTRIES);
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        int addr = (ra + 1 + k) % ENTRIES;
        eb = mem[addr][(ch-1)*8 +: 8];
        sum = (sum + eb) % 256;
        vectors++;
        if (rd_log[k] !== LOG2'(addr) || got[k] !== eb) begin
          miscompares++;
          $display("FAIL dump_byte%0d ch=%0d got addr=%0d b=%h exp addr=%0d b=%h", k, ch, rd_log[k], got[k], addr, eb);
        end
      end
      if (EXTRA == 1) begin
        vectors++;
        if (got[ENTRIES] !== 8'(sum)) begin
          miscompares++; $display("FAIL dump_cksum got %h exp %h", got[ENTRIES], 8'(sum));
        end
      end
    end
  endtask

  task automatic test_dump_invalid();
    logic [15:0] bad [4];
    bad[0] = {2'b10, 1'b0, 5'd0, 8'h00};
    bad[1] = {2'b10, 1'b0, 5'd6, 8'h00};
    bad[2] = {2'b10, 1'b0, 5'd31, 8'h00};
    bad[3] = {2'b11, 14'($urandom)};
    for (int k = 0; k < 4; k++) begin
      run_cmd(bad[k], 0, 0);
      vectors++;
      if (got.size() != 1 || got[0] !== 8'hEE || rd_log.size() != 0 || busy_seen) begin
        miscompares++;
        $display("FAIL nak_%0d got n=%0d resp=%h reads=%0d busy=%0d exp 1 byte EE, 0 reads", k,
                 got.size(), resp, rd_log.size(), busy_seen);
      end
    end
  endtask

  task automatic test_resp_sent_idle();
    int bad = 0;
    @(negedge clk); resp_sent = 1'b1;
    @(negedge clk); resp_sent = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (send_resp || clr_cmd_rdy || dump_busy || rd_en) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL idle_resp_sent got %0d active cycles exp 0", bad);
    end
  endtask

  task automatic test_reset_mid_dump();
    int gap = 0, extra = 0;
    void'(model_write(7, 'h3B));
    run_cmd({2'b01, 6'h07, 8'h3B}, 0, 0);
    fill_mem();
    got.delete();
    @(negedge clk); cmd = {2'b10, 1'b0, 5'd4, 8'h00}; cmd_rdy = 1'b1;
    for (int cyc = 0; cyc < 400 && got.size() < 3; cyc++) begin
      @(negedge clk);
      resp_sent = 1'b0;
      if (send_resp) begin got.push_back(resp); gap = 2; end
      else if (gap > 0) begin gap--; if (gap == 0) resp_sent = 1'b1; end
    end
    rst_n = 1'b0; cmd_rdy = 1'b0; resp_sent = 1'b0;
    init_model();
    #1;
    vectors++;
    if (got.size() != 3 || {dump_busy, send_resp, rd_en, clr_cmd_rdy, resp} !== '0 || act_cfg !== exp_cfg()) begin
      miscompares++;
      $display("FAIL rst_mid_dump got bytes=%0d busy=%b send=%b rd_en=%b clr=%b resp=%h cfg=%h exp 3 bytes, all 0, cfg %h",
               got.size(), dump_busy, send_resp, rd_en, clr_cmd_rdy, resp, act_cfg, exp_cfg());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (send_resp || dump_busy || rd_en) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++; $display("FAIL rst_quiet got %0d active cycles exp 0", extra);
    end
    run_cmd({2'b00, 6'h07, 8'h00}, 0, 0);
    vectors++;
    if (got.size() != 1 || got[0] !== 8'hAA) begin
      miscompares++; $display("FAIL rst_rd_vih got n=%0d resp=%h exp AA", got.size(), resp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; resp_sent = 1'b0;
    set_capture_done = 1'b0; ram_addr = '0;
    vectors = 0; miscompares = 0;
    init_model();
    fill_mem();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_read_map();
    test_write();
    test_capture_done();
    test_dump(7, 2);
    test_dump(3, 1);
    for (int k = 0; k < 6; k++) test_dump($urandom_range(0, ENTRIES-1), $urandom_range(1, NUM_CH));
    test_dump(ENTRIES-2, NUM_CH);
    test_dump_invalid();
    test_resp_sent_idle();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
